// File: rtl/temporizador_regresivo.sv
// Loadable down-counting timer with a programmable prescaler and a one-cycle expiry pulse.
// Build option: define TEMPORIZADOR_AUTO_RELOAD_EN for periodic operation (reload on expiry, DONE unused).
module temporizador_regresivo #(
    parameter int WIDTH    = 4,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] cont_out,
    output logic             busy,
    output logic             done
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Registered FSM state; kept as a named signal so checkers can bind to it.
    state_t           state;
    state_t           state_nxt;
    logic [PRE_W-1:0] pre_cnt;
    logic [PRE_W-1:0] pre_nxt;
    logic [WIDTH-1:0] cont_nxt;
    logic             done_nxt;

`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_nxt;
`endif

    // Load protocol: load is a single-cycle strobe with no handshake. Whenever it is
    // sampled high it wins over en, expiry and the DONE cycle; only rst outranks it.
    // A zero load_val parks the timer in IDLE instead of starting it.
    always_comb begin
        state_nxt = state;
        cont_nxt  = cont_out;
        pre_nxt   = pre_cnt;
        done_nxt  = 1'b0;
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
        reload_nxt = reload_q;
`endif
        if (load) begin
            cont_nxt  = load_val;
            pre_nxt   = '0;
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
            reload_nxt = load_val;
`endif
            state_nxt = (load_val != '0) ? RUN : IDLE;
        end else begin
            unique case (state)
                IDLE: begin
                    state_nxt = IDLE;
                end
                RUN: begin
                    if (en) begin
                        if (pre_cnt == PRE_LAST) begin
                            pre_nxt = '0;
                            if (cont_out == WIDTH'(1)) begin
                                done_nxt = 1'b1;
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
                                cont_nxt  = reload_q;
                                state_nxt = RUN;
`else
                                cont_nxt  = '0;
                                state_nxt = DONE;
`endif
                            end else begin
                                cont_nxt = cont_out - WIDTH'(1);
                            end
                        end else begin
                            pre_nxt = pre_cnt + PRE_W'(1);
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // busy is its own flop so it changes on the same edge as the state it mirrors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cont_out <= '0;
            pre_cnt  <= '0;
            done     <= 1'b0;
            busy     <= 1'b0;
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
            reload_q <= '0;
`endif
        end else begin
            state    <= state_nxt;
            cont_out <= cont_nxt;
            pre_cnt  <= pre_nxt;
            done     <= done_nxt;
            busy     <= (state_nxt == RUN);
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
            reload_q <= reload_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_temporizador_regresivo.sv
// Bench for temporizador_regresivo: two instances (PRESCALE 1 and 3) share stimulus;
// expected {busy,done,cont_out} words are queued when inputs are driven and popped after each edge.
module tb_temporizador_regresivo;

    localparam int W  = 4;
    localparam int PA = 1;
    localparam int PB = 3;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic         load;
    logic [W-1:0] load_val;
    logic [W-1:0] cont_a, cont_b;
    logic         busy_a, busy_b, done_a, done_b;

    logic [5:0] exp_a[$];
    logic [5:0] exp_b[$];
    logic [5:0] ea, eb;
    int checks = 0;
    int passed = 0;

    int mn_a, me_a, mn_b, me_b;
    bit act_a, act_b;

    always #5 clk = ~clk;

    temporizador_regresivo #(.WIDTH(W), .PRESCALE(PA)) u_a (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .cont_out(cont_a), .busy(busy_a), .done(done_a)
    );

    temporizador_regresivo #(.WIDTH(W), .PRESCALE(PB)) u_b (
        .clk(clk), .rst(rst), .en(en), .load(load), .load_val(load_val),
        .cont_out(cont_b), .busy(busy_b), .done(done_b)
    );

    // Reference: after a load of N, the count is N - floor(enabled_edges / P); expiry at N*P.
    task automatic model_step(input int p, input logic l, input logic [W-1:0] lv, input logic e,
                              inout int mn, inout int me, inout bit act, output logic [5:0] w);
        w = '0;
        if (l) begin
            mn  = int'(lv);
            me  = 0;
            act = (lv != '0);
            if (act) w = {2'b10, lv};
        end else if (act) begin
            if (e) me++;
            if (me == mn * p) begin
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
                me = 0;
                w  = {2'b11, W'(mn)};
`else
                act = 1'b0;
                w   = 6'b010000;
`endif
            end else begin
                w = {2'b10, W'(mn - me / p)};
            end
        end
    endtask

    task automatic drive_cycle(input logic l, input logic [W-1:0] lv, input logic e);
        logic [5:0] wa, wb;
        load     = l;
        load_val = lv;
        en       = e;
        model_step(PA, l, lv, e, mn_a, me_a, act_a, wa);
        model_step(PB, l, lv, e, mn_b, me_b, act_b, wb);
        exp_a.push_back(wa);
        exp_b.push_back(wb);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; en = 1'b0; load_val = '0;
        act_a = 1'b0; act_b = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({busy_a, done_a, cont_a, busy_b, done_b, cont_b} !== 12'h000)
            $display("FAIL reset_hold: got %b want 0", {busy_a, done_a, cont_a, busy_b, done_b, cont_b});
        else passed++;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) drive_cycle(1'b1, 4'd7, 1'b1);
            else        drive_cycle(1'b0, 4'd0, 1'b1);
            if (i == 3) begin
                // Mid-cycle reset while both timers are counting.
                #2 rst = 1'b1;
                #1;
                checks++;
                if ({busy_a, done_a, cont_a, busy_b, done_b, cont_b} !== 12'h000)
                    $display("FAIL reset_async: got %b want 0", {busy_a, done_a, cont_a, busy_b, done_b, cont_b});
                else passed++;
                act_a = 1'b0; act_b = 1'b0;
                exp_a.delete(); exp_b.delete();
                @(posedge clk);
                #2 rst = 1'b0;
            end else begin
                ea = exp_a.pop_front(); eb = exp_b.pop_front();
                checks += 2;
                if ({busy_a, done_a, cont_a} !== ea) $display("FAIL reset_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
                else passed++;
                if ({busy_b, done_b, cont_b} !== eb) $display("FAIL reset_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
                else passed++;
            end
        end
    endtask

    task automatic test_one_shot();
        int busy_cnt = 0;
        int done_cnt = 0;
        for (int i = 0; i < 8; i++) begin
            drive_cycle(i == 0, (i == 0) ? 4'd5 : 4'd0, 1'b1);
            busy_cnt += int'(busy_a);
            done_cnt += int'(done_a);
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL one_shot_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL one_shot_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
`ifndef TEMPORIZADOR_AUTO_RELOAD_EN
        checks += 2;
        if (busy_cnt !== 5) $display("FAIL one_shot_busy_len: got %0d want 5", busy_cnt);
        else passed++;
        if (done_cnt !== 1) $display("FAIL one_shot_done_cnt: got %0d want 1", done_cnt);
        else passed++;
`endif
    endtask

    task automatic test_prescaled();
        int first_one = -1;
        int done_at = -1;
        for (int i = 0; i < 9; i++) begin
            drive_cycle(i == 0, (i == 0) ? 4'd2 : 4'd0, 1'b1);
            if (cont_b == 4'd1 && first_one < 0) first_one = i;
            if (done_b && done_at < 0) done_at = i;
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL prescaled_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL prescaled_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
        checks += 2;
        if (first_one !== 3) $display("FAIL prescaled_step: got %0d want 3", first_one);
        else passed++;
        if (done_at !== 6) $display("FAIL prescaled_done: got %0d want 6", done_at);
        else passed++;
    endtask

    task automatic test_pause();
        int done_at = -1;
        for (int i = 0; i < 20; i++) begin
            drive_cycle(i == 0, (i == 0) ? 4'd4 : 4'd0, !(i >= 2 && i <= 4));
            if (done_a && done_at < 0) done_at = i;
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL pause_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL pause_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
        checks++;
        if (done_at !== 7) $display("FAIL pause_done: got %0d want 7", done_at);
        else passed++;
    endtask

    task automatic test_load_priority();
        logic [W-1:0] lv;
        bit l;
        for (int i = 0; i < 8; i++) begin
            l  = (i == 0 || i == 2 || i == 6);
            lv = (i == 0) ? 4'd2 : (i == 2) ? 4'd9 : 4'd0;
            drive_cycle(l, lv, 1'b1);
            if (i == 2) begin
                checks++;
                if ({busy_a, done_a, cont_a} !== 6'b10_1001)
                    $display("FAIL load_over_expiry: got %b want 101001", {busy_a, done_a, cont_a});
                else passed++;
            end
            if (i == 6) begin
                checks++;
                if ({busy_a, done_a, cont_a, busy_b, done_b, cont_b} !== 12'h000)
                    $display("FAIL load_zero: got %b want 0", {busy_a, done_a, cont_a, busy_b, done_b, cont_b});
                else passed++;
            end
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL priority_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL priority_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
    endtask

    task automatic test_load_during_done();
        for (int i = 0; i < 6; i++) begin
            drive_cycle(i == 0 || i == 2, (i == 0) ? 4'd1 : (i == 2) ? 4'd3 : 4'd0, 1'b1);
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL back_to_back_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL back_to_back_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
    endtask

`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
    task automatic test_auto_reload();
        int done_cnt = 0;
        int busy_low = 0;
        for (int i = 0; i < 10; i++) begin
            drive_cycle(i == 0, (i == 0) ? 4'd3 : 4'd0, 1'b1);
            done_cnt += int'(done_a);
            busy_low += int'(!busy_a);
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL auto_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL auto_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
        checks += 2;
        if (done_cnt !== 3) $display("FAIL auto_done_cnt: got %0d want 3", done_cnt);
        else passed++;
        if (busy_low !== 0) $display("FAIL auto_busy: got %0d low cycles want 0", busy_low);
        else passed++;
    endtask
`endif

    task automatic test_random();
        logic l;
        logic [W-1:0] lv;
        logic e;
        for (int i = 0; i < 120; i++) begin
            l  = ($urandom_range(0, 11) == 0);
            lv = W'($urandom_range(0, 15));
            e  = ($urandom_range(0, 3) != 0);
            drive_cycle(l, lv, e);
            ea = exp_a.pop_front(); eb = exp_b.pop_front();
            checks += 2;
            if ({busy_a, done_a, cont_a} !== ea) $display("FAIL random_a cyc %0d: got %b want %b", i, {busy_a, done_a, cont_a}, ea);
            else passed++;
            if ({busy_b, done_b, cont_b} !== eb) $display("FAIL random_b cyc %0d: got %b want %b", i, {busy_b, done_b, cont_b}, eb);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_prescaled();
        test_pause();
        test_load_priority();
        test_load_during_done();
`ifdef TEMPORIZADOR_AUTO_RELOAD_EN
        test_auto_reload();
`endif
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/temporizador_regresivo.md
# temporizador_regresivo

Loadable down-counting timer with a programmable prescaler, used by the Proyecto_3 datapath to time intervals set by the control logic. It is the countdown counterpart of the free-running up-counter `Contador`. It accepts a start value, decrements under `en` at a prescaled rate, and flags expiry with a one-cycle `done` pulse. The block sits beside `Contador` on the same clock and reset, and its count is exported for display or debug.

## Interface
- `WIDTH`, 4, bit width of the count and of the load value (2..16).
- `PRESCALE`, 1, number of enabled clock cycles per decrement (1..256).

- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en`  in  1  count enable; low freezes the prescaler and the count (pause).
- `load`  in  1  single-cycle strobe; captures `load_val` and starts the timer.
- `load_val`  in  WIDTH  start value, unsigned.
- `cont_out`  out  WIDTH  current remaining count, registered.
- `busy`  out  1  high while the FSM is in RUN, registered.
- `done`  out  1  one-cycle expiry pulse, registered.

## Operation
- FSM states are IDLE, RUN and DONE.
- **Reset:**
  - Takes effect immediately, regardless of `clk`.
  - State goes to IDLE; `cont_out`=0, `busy`=0, `done`=0.
  - Prescaler counter `pre_cnt` = 0; reload register = 0.
- **Load handling:** `load`=1 in any state has top priority over everything except reset.
  - `cont_out` <= `load_val`, `pre_cnt` <= 0, reload register <= `load_val`, `done` <= 0.
  - If `load_val` != 0, next state is RUN; otherwise next state is IDLE.
- **IDLE:** holds `cont_out`; ignores `en`.
- **RUN:**
  - With `en`=1, `pre_cnt` increments.
  - When `pre_cnt` == PRESCALE-1, `pre_cnt` <= 0 and `cont_out` decrements by 1.
  - With `en`=0, nothing changes.
- **Terminal decrement** (decrement from `cont_out`==1):
  - `cont_out` <= 0, `done` <= 1, next state DONE.
- **DONE:** lasts exactly one cycle. `done` <= 0 and next state is IDLE. `cont_out` stays 0.
- **Arithmetic:** plain unsigned decrement.
  - `cont_out` never wraps below 0, because the timer never decrements in IDLE or DONE.
  - `pre_cnt` is ceil(log2(PRESCALE)) bits, with a minimum of 1 bit.
- **Simultaneous events:**
  - `load` coinciding with a terminal decrement: load wins and no `done` is produced.
  - `load` during DONE: load wins and the new count starts.
- `busy` = 1 exactly when the registered state is RUN.

## Timing
- **Load latency:** `load` sampled at edge k gives `cont_out`=`load_val` and `busy`=1 after edge k.
- **Decrement rate:** with `en` held high, one decrement per PRESCALE cycles. The first decrement occurs at edge k+PRESCALE.
- **Expiry:**
  - Load of N at edge k with `en` continuously high gives `cont_out`=0 and `done`=1 after edge k+N·PRESCALE.
  - `done` falls after the next edge; `busy` falls at the same edge that `done` rises.
- **Pause:** the timer stretches by exactly the number of cycles `en` is low while in RUN.
- **Reset mid-count:** all outputs are at their reset values within the same cycle. No `done` pulse is emitted.

## Configuration
- **`TEMPORIZADOR_AUTO_RELOAD_EN` defined:**
  - On a terminal decrement, `cont_out` <= reload register, `done` <= 1, and the state stays RUN with `pre_cnt`=0.
  - The timer runs periodically with period reload·PRESCALE cycles. DONE is never entered.
  - A load of 0 still goes to IDLE.
- **Macro undefined:** one-shot behaviour as described in Operation. The reload register may be optimised away.

## Test plan
- **Reset:** `rst`=1 asynchronously mid-cycle -> `cont_out`=0, `busy`=0, `done`=0 before the next edge. Release `rst` -> outputs stay at 0 with `load`=0.
- **One-shot count:** WIDTH=4, PRESCALE=1, load 5 with `en`=1 -> `cont_out` sequence 5,4,3,2,1,0. `done`=1 only in the cycle `cont_out` first equals 0; `busy` high for 5 cycles.
- **Prescaled count:** PRESCALE=3, load 2 -> `cont_out` steps 2→1 after 3 cycles, 1→0 after 6 cycles; `done` pulses at cycle 6.
- **Pause:** load 4, drop `en` for 3 cycles after the first decrement -> `cont_out` holds at 3 for 3 cycles; expiry is delayed by exactly 3 cycles.
- **Load priority:** assert `load` with `load_val`=9 in the same cycle as the terminal decrement -> no `done`, `cont_out`=9, `busy`=1. A separate load of 0 -> `cont_out`=0, `busy`=0, `done`=0.
- **Auto-reload** (macro defined): load 3 with `en`=1 -> `cont_out` 3,2,1,3,2,1,3…; `done` pulses every 3 cycles, coincident with each reload; `busy` stays 1.
